// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: host-loaded sample buffer streamed to an FIR on request,
// with a show-ahead result FIFO capturing the FIR outputs.
module fir_sample_feeder #(
    parameter int unsigned SDEPTH = 16,
    parameter int unsigned RDEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [31:0]               wr_data,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      next,
    input  logic                      fir_ready,
    input  logic [31:0]               fir_out,
    output logic [31:0]               sample,
    output logic                      stop,
    input  logic                      rd_en,
    output logic [31:0]               rd_data,
    output logic [$clog2(RDEPTH):0]   res_count,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int unsigned SIDX_W = $clog2(SDEPTH);
    localparam int unsigned SCNT_W = SIDX_W + 1;
    localparam int unsigned RPTR_W = $clog2(RDEPTH);
    localparam int unsigned RCNT_W = RPTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e              state_q;
    logic [SCNT_W-1:0]   scount_q;
    logic [SIDX_W-1:0]   idx_q;
    logic                stop_q;
    logic                busy_q;
    logic                done_q;

    logic                next_q;
    logic                rdy_q;

    logic [31:0]         sbuf [SDEPTH];
    logic [31:0]         rmem [RDEPTH];
    logic [RPTR_W-1:0]   wptr_q;
    logic [RPTR_W-1:0]   rptr_q;
    logic [RCNT_W-1:0]   rcount_q;
    logic                overflow_q;

    logic                next_edge;
    logic                rdy_edge;
    logic                active;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                drop;
    logic                sbuf_we;
    logic                idx_last;

    // Edge detection and FIFO / buffer handshake decode
    always_comb begin
        next_edge  = next & ~next_q;
        rdy_edge   = fir_ready & ~rdy_q;
        active     = (state_q == StStream) || (state_q == StDrain);
        fifo_full  = (rcount_q == RCNT_W'(RDEPTH));
        fifo_empty = (rcount_q == '0);
        pop        = rd_en & ~fifo_empty;
        // A pop in the same cycle frees a slot, so a push at full still lands.
        push       = rdy_edge & active & (~fifo_full | pop);
        drop       = rdy_edge & active & fifo_full & ~pop;
        sbuf_we    = (state_q == StIdle) & wr_en & (scount_q < SCNT_W'(SDEPTH));
        idx_last   = ({1'b0, idx_q} == (scount_q - SCNT_W'(1)));
    end

    // Output drive: sample and FIFO head are combinational reads
    always_comb begin
        sample    = active ? sbuf[idx_q] : '0;
        rd_data   = fifo_empty ? '0 : rmem[rptr_q];
        res_count = rcount_q;
        stop      = stop_q;
        busy      = busy_q;
        done      = done_q;
        overflow  = overflow_q;
    end

    // One-cycle delayed copies of the FIR strobes for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            next_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            next_q <= next;
            rdy_q  <= fir_ready;
        end
    end

    // Sample buffer storage (no reset needed, scount gates validity)
    always_ff @(posedge clk) begin
        if (!rst && sbuf_we) begin
            sbuf[scount_q[SIDX_W-1:0]] <= wr_data;
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            rmem[wptr_q] <= fir_out;
        end
    end

    // Result FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rcount_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + RPTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + RPTR_W'(1);
            end
            case ({push, pop})
                2'b10:   rcount_q <= rcount_q + RCNT_W'(1);
                2'b01:   rcount_q <= rcount_q - RCNT_W'(1);
                default: rcount_q <= rcount_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            scount_q <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sbuf_we) begin
                        scount_q <= scount_q + SCNT_W'(1);
                    end
                    if (start && (scount_q != '0)) begin
                        idx_q   <= '0;
                        state_q <= StStream;
                        busy_q  <= 1'b1;
                    end
                end
                StStream: begin
                    if (next_edge) begin
                        if (idx_last) begin
                            state_q <= StDrain;
                            stop_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + SIDX_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (rdy_edge) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (clear) begin
                        state_q  <= StIdle;
                        scount_q <= '0;
                        idx_q    <= '0;
                        stop_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    stop_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_fir_sample_feeder;

    localparam int SDEPTH = 16;
    localparam int RDEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        next = 1'b0;
    logic        fir_ready = 1'b0;
    logic [31:0] fir_out = '0;
    logic [31:0] sample;
    logic        stop;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [$clog2(RDEPTH):0] res_count;
    logic        busy;
    logic        done;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    fir_sample_feeder #(
        .SDEPTH(SDEPTH),
        .RDEPTH(RDEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .clear     (clear),
        .next      (next),
        .fir_ready (fir_ready),
        .fir_out   (fir_out),
        .sample    (sample),
        .stop      (stop),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .res_count (res_count),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=stream 2=drain 3=done
    int          m_mode = 0;
    int          m_scount = 0;
    int          m_idx = 0;
    logic [31:0] m_buf [SDEPTH];
    logic [31:0] m_res [$];
    bit          m_ovf = 0;
    bit          m_next_prev = 0;
    bit          m_rdy_prev = 0;

    always @(posedge clk) begin
        bit ne;
        bit re;
        bit can_pop;
        int old_scount;
        if (rst) begin
            m_mode = 0; m_scount = 0; m_idx = 0; m_ovf = 0;
            m_next_prev = 0; m_rdy_prev = 0;
            m_res.delete();
        end else begin
            ne = next && !m_next_prev;
            re = fir_ready && !m_rdy_prev;
            m_next_prev = next;
            m_rdy_prev = fir_ready;
            can_pop = rd_en && (m_res.size() > 0);
            if (can_pop) void'(m_res.pop_front());
            if (re && (m_mode == 1 || m_mode == 2)) begin
                if (m_res.size() < RDEPTH) m_res.push_back(fir_out);
                else m_ovf = 1;
            end
            case (m_mode)
                0: begin
                    old_scount = m_scount;
                    if (wr_en && m_scount < SDEPTH) begin
                        m_buf[m_scount] = wr_data;
                        m_scount++;
                    end
                    if (start && old_scount > 0) begin
                        m_idx = 0;
                        m_mode = 1;
                    end
                end
                1: if (ne) begin
                    if (m_idx < m_scount - 1) m_idx++;
                    else m_mode = 2;
                end
                2: if (re) m_mode = 3;
                default: if (clear) begin
                    m_mode = 0; m_scount = 0; m_idx = 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        bit act;
        act = (m_mode == 1 || m_mode == 2);
        check("m_sample", sample, act ? m_buf[m_idx] : 32'h0);
        check("m_stop", 32'(stop), 32'(m_mode == 2 || m_mode == 3));
        check("m_busy", 32'(busy), 32'(act));
        check("m_done", 32'(done), 32'(m_mode == 3));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
        check("m_res_count", 32'(res_count), 32'(m_res.size()));
        check("m_rd_data", rd_data, (m_res.size() > 0) ? m_res[0] : 32'h0);
    endtask

    // Advance one clock; compare on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse_next();
        next = 1'b1; step(); next = 1'b0; step();
    endtask

    task automatic pulse_rdy(input logic [31:0] v);
        fir_out = v; fir_ready = 1'b1; step(); fir_ready = 1'b0; step();
    endtask

    task automatic load(input logic [31:0] v);
        wr_data = v; wr_en = 1'b1; step(); wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_sample", sample, 32'h0);
        check("rst_count", 32'(res_count), 32'h0);
        check("rst_flags", {28'h0, stop, busy, done, overflow}, 32'h0);

        // Start with nothing loaded, then overfill the sample buffer
        start = 1'b1; step(); start = 1'b0;
        check("empty_start_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 17; i++) load(32'h1000 + 32'(i));
        start = 1'b1; step(); start = 1'b0;
        check("full_start_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 15; i++) pulse_next();
        check("full_last_sample", sample, 32'h100F);
        check("full_stop_pre", 32'(stop), 32'h0);
        pulse_next();
        check("full_stop", 32'(stop), 32'h1);
        check("full_drain_sample", sample, 32'h100F);
        pulse_rdy(32'h55);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_idle", {30'h0, done, stop}, 32'h0);
        do_reset();

        // Three-sample stream with a held next
        load(32'h3F800000);
        load(32'h40000000);
        load(32'h40400000);
        start = 1'b1; step(); start = 1'b0;
        check("s0", sample, 32'h3F800000);
        next = 1'b1;
        for (int i = 0; i < 5; i++) step();
        next = 1'b0; step();
        check("held_next_s1", sample, 32'h40000000);
        pulse_next();
        check("s2", sample, 32'h40400000);
        check("s2_stop", 32'(stop), 32'h0);
        pulse_next();
        check("drain_stop", 32'(stop), 32'h1);
        check("drain_busy", 32'(busy), 32'h1);
        fir_out = 32'h41200000; fir_ready = 1'b1; step(); fir_ready = 1'b0;
        check("drain_count", 32'(res_count), 32'h1);
        check("drain_rd", rd_data, 32'h41200000);
        check("drain_done", 32'(done), 32'h1);
        pulse_rdy(32'hDEAD);
        check("done_ignores_rdy", 32'(res_count), 32'h1);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        check("pop_count", 32'(res_count), 32'h0);
        check("pop_rd_zero", rd_data, 32'h0);

        // Fill result FIFO past its depth while streaming
        clear = 1'b1; step(); clear = 1'b0;
        load(32'h1);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 17; i++) pulse_rdy(32'hA000 + 32'(i));
        check("full_count", 32'(res_count), 32'(RDEPTH));
        check("full_ovf", 32'(overflow), 32'h1);
        check("full_head", rd_data, 32'hA000);
        fir_out = 32'hBEEF; fir_ready = 1'b1; rd_en = 1'b1; step();
        fir_ready = 1'b0; rd_en = 1'b0;
        check("pushpop_count", 32'(res_count), 32'(RDEPTH));
        for (int i = 1; i < 16; i++) begin
            check("drain_order", rd_data, 32'hA000 + 32'(i));
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        check("drain_tail", rd_data, 32'hBEEF);

        // Reset mid-stream at idx 2
        do_reset();
        for (int i = 0; i < 4; i++) load(32'hC0 + 32'(i));
        start = 1'b1; step(); start = 1'b0;
        pulse_rdy(32'h77);
        pulse_next();
        pulse_next();
        check("pre_rst_sample", sample, 32'hC2);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_sample", sample, 32'h0);
        check("mid_rst_count", 32'(res_count), 32'h0);
        check("mid_rst_flags", {28'h0, stop, busy, done, overflow}, 32'h0);
        start = 1'b1; step(); start = 1'b0;
        check("mid_rst_bufempty", 32'(busy), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 400) == 0;
            wr_en     = ($urandom % 3) == 0;
            wr_data   = $urandom;
            start     = ($urandom % 15) == 0;
            clear     = ($urandom % 10) == 0;
            next      = ($urandom % 2) == 0;
            fir_ready = ($urandom % 3) == 0;
            fir_out   = $urandom;
            rd_en     = ($urandom % 5) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter: SDEPTH, 16, sample buffer entries, power of two.
REQ-002 Parameter: RDEPTH, 16, result FIFO entries, power of two.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en / wr_data  in  1 / 32  host loads one IEEE-754 single sample per cycle.
REQ-006 start  in  1  host pulse that begins streaming.
REQ-007 clear  in  1  host pulse that returns DONE to IDLE.
REQ-008 next  in  1  sample request from the FIR; one new sample per rising edge.
REQ-009 fir_ready / fir_out  in  1 / 32  FIR result strobe and value.
REQ-010 sample  out  32  sample word driven to the FIR data input.
REQ-011 stop  out  1  tells the FIR that the sample stream is exhausted.
REQ-012 rd_en  in  1  host pops the result FIFO head.
REQ-013 rd_data  out  32  result FIFO head (show-ahead).
REQ-014 res_count  out  $clog2(RDEPTH)+1  results held.
REQ-015 busy / done / overflow  out  1 each  status flags.

Function
REQ-016 The block SHALL implement FSM states IDLE, STREAM, DRAIN and DONE.
REQ-017 In IDLE, wr_en with scount<SDEPTH SHALL write wr_data to buf[scount] and increment scount; wr_en at full or outside IDLE SHALL be ignored.
REQ-018 start in IDLE with scount>0 SHALL set idx=0 and enter STREAM next cycle; start with scount==0 or outside IDLE SHALL be ignored.
REQ-019 sample SHALL equal buf[idx] combinationally in STREAM and DRAIN, and 0 otherwise.
REQ-020 The block SHALL register next and fir_ready one cycle (next_d, rdy_d); an edge is signal&&!delayed.
REQ-021 A next edge in STREAM with idx<scount-1 SHALL increment idx.
REQ-022 A next edge in STREAM with idx==scount-1 SHALL hold idx, set stop=1 and enter DRAIN.
REQ-023 stop SHALL stay 1 through DRAIN and DONE, and be 0 in IDLE and STREAM.
REQ-024 A fir_ready edge in STREAM or DRAIN SHALL push fir_out if res_count<RDEPTH; at full the value SHALL be dropped and overflow set (sticky until rst).
REQ-025 A fir_ready edge in DRAIN SHALL, after its push, enter DONE next cycle.
REQ-026 fir_ready edges in IDLE or DONE SHALL be ignored.
REQ-027 rd_en with res_count>0 SHALL pop the head; rd_en when empty SHALL be ignored; rd_data SHALL be 0 when empty.
REQ-028 A simultaneous push and pop SHALL both occur, leaving res_count unchanged; a push when full with a pop in the same cycle SHALL succeed.
REQ-029 FIFO pointers SHALL wrap modulo RDEPTH.
REQ-030 busy SHALL be 1 in STREAM and DRAIN; done SHALL be 1 in DONE.
REQ-031 clear in DONE SHALL enter IDLE with scount=0 and idx=0 while retaining FIFO contents; clear in other states SHALL be ignored.
REQ-032 next and fir_ready edges SHALL act on the cycle after the edge is registered (1-cycle latency).

Reset
REQ-033 rst SHALL force IDLE with scount, idx and all FIFO pointers 0; sample=0, stop=0, busy=0, done=0, overflow=0, res_count=0, rd_data=0.
REQ-034 rst SHALL take priority over every other input, including mid-STREAM; no push or pop SHALL occur on a reset cycle.

Verification
REQ-035 Load 3 samples 3F800000/40000000/40400000, start, 3 next pulses -> sample shows 3F800000, 40000000, 40400000; stop=1 after the 3rd next edge; state is DRAIN.
REQ-036 In DRAIN, fir_ready edge with fir_out=41200000 -> res_count=1, rd_data=41200000, done=1 one cycle later; rd_en -> res_count=0.
REQ-037 next held high for 5 cycles -> idx advances exactly once.
REQ-038 17 fir_ready edges with no reads (RDEPTH=16) -> res_count=16, overflow=1, 17th value absent; push and pop on the same cycle at full -> count stays 16.
REQ-039 start with scount=0 -> remains IDLE; wr_en 17 times -> scount=16 and the 17th write is dropped.
REQ-040 rst asserted mid-STREAM at idx=2 -> next cycle IDLE, all outputs at reset values, buffers empty.
